clk_div_prog: RTL and testbench

- Synthesizable programmable integer clock divider. Consumes the free-running system clock produced by the bench clock generators and produces a divided clock, a rising-edge tick and a lock flag for downstream logic.
- The divisor is reloaded at run time through a valid/ready handshake.
- Divisor swaps and stops take effect only at period boundaries, so clk_out never glitches.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_prog_if.sv | 23 ++
 rtl/clk_div_cnt.sv | 40 ++++
 rtl/clk_div_prog.sv | 147 ++++++++++++++
 tb/tb_clk_div_prog.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the FSM state encoding, the minimum legal divisor and the
// divisor clamp used when a new divisor is accepted.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Smallest divisor that still gives one high and one low cycle.
  localparam int unsigned DIV_MIN = 2;

  // Raise divisors below DIV_MIN to DIV_MIN; larger values pass through.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Divisor reload channel of the programmable clock divider.
// valid/ready: the requester drives div_in and div_valid and holds them
// until a cycle where div_valid && div_ready is seen at a rising clk edge;
// that edge transfers div_in. div_ready never depends on div_valid.
interface clk_div_prog_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;

  modport master (
    output div_in,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_in,
    input  div_valid,
    output div_ready
  );
endinterface

// File: rtl/clk_div_cnt.sv
// Period counter for the clock divider.
// Holds cnt, flags the last cycle of a period, and precomputes the
// next-cycle high/low level and wrap so the top can register clk_out
// and tick from next-state values.
module clk_div_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,        // divider is running this cycle
  input  logic             run_n,      // divider will be running next cycle
  input  logic [CNT_W-1:0] div,        // divisor in effect this cycle
  input  logic [CNT_W-1:0] div_n,      // divisor in effect next cycle
  output logic [CNT_W-1:0] cnt,
  output logic             period_end,
  output logic             hi_next,
  output logic             wrap_next
);
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W:0]   hi_w;

  assign period_end = (cnt == div - CNT_W'(1));

  // Count up while running; restart at 0 on wrap, on start and when idle.
  assign cnt_n = (adv && run_n && !period_end) ? cnt + CNT_W'(1) : '0;

  // High time is ceil(div/2), computed one bit wider so div=max cannot overflow.
  assign hi_w      = ({1'b0, div_n} + (CNT_W + 1)'(1)) >> 1;
  assign hi_next   = ({1'b0, cnt_n} < hi_w);
  assign wrap_next = (cnt_n == '0);

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end
endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider (top level).
// Produces a glitch-free registered clk_out, a tick on each rising edge of
// clk_out and a locked flag. Divisor swaps and stops are deferred to period
// boundaries. Optional build macro CLK_DIV_PERIOD_CNT_EN adds a saturating
// period_cnt output counting ticks since the divider last left IDLE.
// The state and cnt outputs expose the FSM state and period position.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  clk_div_prog_if.slave    div_if,
  output logic             clk_out,
  output logic             tick,
  output logic             locked,
  output logic [CNT_W-1:0] div_cur,
  output state_t           state,
  output logic [CNT_W-1:0] cnt
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);
  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  state_t           state_n;
  logic [CNT_W-1:0] div_n;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pend_n;
  logic [CNT_W-1:0] div_req;
  logic             ready_q;
  logic             xfer;
  logic             locked_n;
  logic             stop_q;
  logic             stop_n;
  logic             has_pend;
  logic             adv;
  logic             run_n;
  logic             period_end;
  logic             hi_next;
  logic             wrap_next;

  assign div_if.div_ready = ready_q;
  assign xfer             = div_if.div_valid && ready_q;
  assign div_req          = CNT_W'(clamp_div(32'(div_if.div_in)));
  assign adv              = (state != IDLE);
  assign run_n            = (state_n != IDLE);

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .adv        (adv),
    .run_n      (run_n),
    .div        (div_cur),
    .div_n      (div_n),
    .cnt        (cnt),
    .period_end (period_end),
    .hi_next    (hi_next),
    .wrap_next  (wrap_next)
  );

  // Next-state decode: handshake, deferred swap, deferred stop and lock.
  // A low en is remembered in stop_q so the period in flight still finishes.
  always_comb begin
    state_n  = state;
    div_n    = div_cur;
    pend_n   = pend;
    locked_n = locked;
    stop_n   = stop_q;
    has_pend = 1'b0;
    case (state)
      IDLE: begin
        locked_n = 1'b0;
        stop_n   = 1'b0;
        if (xfer) div_n = div_req;
        if (en) state_n = RUN;
      end
      RUN, PEND: begin
        if (!en) stop_n = 1'b1;
        if (xfer) begin
          pend_n  = div_req;
          state_n = PEND;
        end
        has_pend = (state_n == PEND);
        if (period_end) begin
          if (stop_n) begin
            // Stopping: any held divisor (even one accepted now) is applied.
            state_n  = IDLE;
            locked_n = 1'b0;
            stop_n   = 1'b0;
            if (has_pend) div_n = pend_n;
          end else if (state == PEND) begin
            state_n  = RUN;
            div_n    = pend;
            locked_n = 1'b0;
          end else begin
            // A full period at div_cur has completed.
            locked_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM and registered outputs; clk_out/tick come from next-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cur <= DIV_RST_V;
      pend    <= '0;
      ready_q <= 1'b1;
      locked  <= 1'b0;
      stop_q  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cur <= div_n;
      pend    <= pend_n;
      ready_q <= (state_n != PEND);
      locked  <= locked_n;
      stop_q  <= stop_n;
      clk_out <= run_n && hi_next;
      tick    <= run_n && wrap_next;
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  // Saturating count of ticks, restarted whenever the divider returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (state != IDLE && state_n == IDLE) begin
      period_cnt <= '0;
    end else if (tick && period_cnt != 16'hFFFF) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios with literal expectations
// followed by randomized en/divisor/reset traffic, all compared cycle by
// cycle against a period-level behavioural model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 2;
  localparam int W       = 2 + 1 + 1 + 1 + 1 + CNT_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic             clk_out;
  logic             tick;
  logic             locked;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] cnt;
  state_t           dut_state;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  clk_div_prog_if #(.CNT_W(CNT_W)) div_if ();

  clk_div_prog #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_if     (div_if),
    .clk_out    (clk_out),
    .tick       (tick),
    .locked     (locked),
    .div_cur    (div_cur),
    .state      (dut_state),
    .cnt        (cnt)
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: running or not, position within the current period, divisor in
  // effect, an optional held divisor, a deferred stop request and lock.
  bit m_run;
  int m_phase;
  int m_div;
  int m_pend;
  bit m_pv;
  bit m_stop;
  bit m_lock;

  function automatic logic [W-1:0] model_out();
    state_t s;
    logic   co;
    logic   tk;
    s  = !m_run ? IDLE : (m_pv ? PEND : RUN);
    co = m_run && (m_phase < (m_div + 1) / 2);
    tk = m_run && (m_phase == 0);
    return {s, !m_pv, co, tk, m_lock, CNT_W'(m_div), CNT_W'(m_phase)};
  endfunction

  always @(posedge clk) begin : model_step
    bit acc;
    bit had;
    int req;
    if (rst) begin
      m_run = 0; m_phase = 0; m_div = DIV_RST; m_pend = 0;
      m_pv = 0; m_stop = 0; m_lock = 0;
    end else begin
      acc = div_if.div_valid && !m_pv;
      req = (int'(div_if.div_in) < 2) ? 2 : int'(div_if.div_in);
      if (!m_run) begin
        if (acc) m_div = req;
        if (en) begin
          m_run = 1; m_phase = 0;
        end
      end else begin
        had = m_pv;
        if (!en) m_stop = 1;
        if (acc) begin
          m_pend = req; m_pv = 1;
        end
        if (m_phase == m_div - 1) begin
          m_phase = 0;
          if (m_stop) begin
            m_run = 0; m_lock = 0; m_stop = 0;
            if (m_pv) m_div = m_pend;
            m_pv = 0;
          end else if (had) begin
            m_div = m_pend; m_pv = 0; m_lock = 0;
          end else begin
            m_lock = 1;
          end
        end else begin
          m_phase++;
        end
      end
    end
    exp_q.push_back(model_out());
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {dut_state, div_if.div_ready, clk_out, tick, locked, div_cur, cnt}, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [CNT_W-1:0] d);
    int guard;
    guard = 0;
    div_if.div_in    = d;
    div_if.div_valid = 1'b1;
    while (!div_if.div_ready && guard < 300) begin
      cyc();
      guard++;
    end
    check("load_wait", 32'(guard < 300), 32'd1);
    cyc();
    div_if.div_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] co, output logic [31:0] tk,
                         output logic [31:0] lk, output logic [31:0] rd);
    co = '0; tk = '0; lk = '0; rd = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      co = {co[30:0], clk_out};
      tk = {tk[30:0], tick};
      lk = {lk[30:0], locked};
      rd = {rd[30:0], div_if.div_ready};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] co, tk, lk, rd;
    bit will_acc;
    div_if.div_in    = '0;
    div_if.div_valid = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state.
    check("rst_div_cur", 32'(div_cur), 32'd2);
    check("rst_ready",   32'(div_if.div_ready), 32'd1);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_locked",  32'(locked), 32'd0);
    check("rst_state",   32'(dut_state), 32'(IDLE));

    // Divide by 4 from IDLE.
    load(8'd4);
    check("t1_div_cur", 32'(div_cur), 32'd4);
    en = 1'b1;
    capture(8, co, tk, lk, rd);
    check("t1_clk_out", co, 32'hCC);
    check("t1_tick",    tk, 32'h88);
    check("t1_locked",  lk, 32'h0F);

    // Accept 6 at cnt=1 while running at 4.
    cyc(); cyc();
    check("t3_cnt", 32'(cnt), 32'd1);
    div_if.div_in    = 8'd6;
    div_if.div_valid = 1'b1;
    cyc();
    div_if.div_valid = 1'b0;
    check("t3_ready_low", 32'(div_if.div_ready), 32'd0);
    check("t3_state",     32'(dut_state), 32'(PEND));
    capture(8, co, tk, lk, rd);
    check("t3_clk_out", co, 32'h71);
    check("t3_ready",   rd, 32'h7F);
    check("t3_locked",  lk, 32'h81);
    check("t3_div_cur", 32'(div_cur), 32'd6);

    // Drop en at cnt=1 with div=6.
    cyc();
    en = 1'b0;
    capture(6, co, tk, lk, rd);
    check("t5_clk_out", co, 32'h20);
    check("t5_locked",  lk, 32'h3C);
    check("t5_state",   32'(dut_state), 32'(IDLE));

    // Divisor 1 clamps to 2.
    load(8'd1);
    check("t4_div_cur", 32'(div_cur), 32'd2);
    en = 1'b1;
    capture(4, co, tk, lk, rd);
    check("t4_clk_out", co, 32'hA);
    check("t4_tick",    tk, 32'hA);

    // Stop, then divide by 5.
    en = 1'b0;
    cyc();
    check("t2_idle", 32'(dut_state), 32'(IDLE));
    load(8'd5);
    check("t2_div_cur", 32'(div_cur), 32'd5);
    en = 1'b1;
    capture(10, co, tk, lk, rd);
    check("t2_clk_out", co, 32'h39C);

    // Reset while a divisor is pending.
    load(8'd3);
    check("t6_pend", 32'(dut_state), 32'(PEND));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_clk_out", 32'(clk_out), 32'd0);
    check("t6_div_cur", 32'(div_cur), 32'd2);
    check("t6_ready",   32'(div_if.div_ready), 32'd1);
    check("t6_state",   32'(dut_state), 32'(IDLE));
`ifdef CLK_DIV_PERIOD_CNT_EN
    check("t6_period_cnt", 32'(period_cnt), 32'd0);
`endif
    capture(6, co, tk, lk, rd);
    check("t6_clk_after", co, 32'h2A);
    check("t6_div_kept",  32'(div_cur), 32'd2);

    // Randomized traffic; requests are held until accepted.
    will_acc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!(div_if.div_valid && !will_acc)) begin
        div_if.div_valid = ($urandom_range(0, 5) == 0);
        div_if.div_in    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 255))
                                                       : CNT_W'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 24) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      will_acc = div_if.div_valid && div_if.div_ready && !rst;
      cyc();
    end
    rst = 1'b0;
    div_if.div_valid = 1'b0;
    en = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
